// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared state encoding, control-bundle layout and stage widths for pipeline registers
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_BRTYPE   = 5;
    localparam int CTRL_JUMP     = 6;

    localparam int STAGE_CTRL_W  = 8;
    localparam int STAGE_DATA_W  = 128;
    localparam int IFID_DATA_W   = 64;
    localparam int IDEX_DATA_W   = 128;
    localparam int EXMEM_DATA_W  = 128;
    localparam int MEMWB_DATA_W  = 80;

    // Occupancy is simply the number of entries whose valid bit is set.
    function automatic logic [1:0] occupancy(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one valid+ctrl+data holding register with load enable and valid clear
module pipe_entry_reg
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = STAGE_CTRL_W,
    parameter int DATA_W = STAGE_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Clear wins over load; payload only moves on load so stale data is held, never cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= clr_i ? 1'b0 : (ld_i ? 1'b1 : valid_q);
            if (ld_i) begin
                ctrl_q <= ctrl_i;
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble gating and optional skid entry
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W = STAGE_CTRL_W,
    parameter int DATA_W = STAGE_DATA_W,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    state_e            state_q, state_d;
    logic              in_rdy_q;
    logic              in_xfer, out_xfer;
    logic              main_ld, main_clr, skid_ld, skid_clr;
    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_c, skid_c, main_in_c;
    logic [DATA_W-1:0] main_d, skid_d, main_in_d;

    assign in_xfer    = in_valid_i & in_ready_o;
    assign out_xfer   = main_v & out_ready_i;
    // in_rdy_q holds ready low through reset; with a skid entry it is the whole ready term.
    assign in_ready_o = (SKID != 0) ? in_rdy_q : in_rdy_q & (~main_v | out_ready_i);

    // State register plus registered ready (low in FULL, and low until the first edge after reset).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_rdy_q <= state_d != ST_FULL;
        end
    end

    // Next state: flush dominates, FULL only reachable when a skid entry exists.
    always_comb begin
        state_d = state_q;
        if (flush_i)
            state_d = ST_EMPTY;
        else if (state_q == ST_EMPTY)
            state_d = in_xfer ? ST_BUSY : ST_EMPTY;
        else if (state_q == ST_BUSY)
            state_d = (in_xfer & ~out_xfer & (SKID != 0)) ? ST_FULL :
                      (~in_xfer & out_xfer) ? ST_EMPTY : ST_BUSY;
        else
            state_d = out_xfer ? ST_BUSY : ST_FULL;
    end

    // Entry controls: main always holds the oldest entry, skid refills main when it drains.
    always_comb begin
        main_ld   = ~flush_i & (((state_q == ST_EMPTY) & in_xfer) |
                                ((state_q == ST_BUSY) & in_xfer & out_xfer) |
                                ((state_q == ST_FULL) & out_xfer));
        main_clr  = flush_i | ((state_q == ST_BUSY) & out_xfer & ~in_xfer);
        skid_ld   = (SKID != 0) & ~flush_i & (state_q == ST_BUSY) & in_xfer & ~out_xfer;
        skid_clr  = flush_i | ((state_q == ST_FULL) & out_xfer);
        main_in_c = (state_q == ST_FULL) ? skid_c : in_ctrl_i;
        main_in_d = (state_q == ST_FULL) ? skid_d : in_data_i;
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ld_i    (main_ld),
        .clr_i   (main_clr),
        .ctrl_i  (main_in_c),
        .data_i  (main_in_d),
        .valid_o (main_v),
        .ctrl_o  (main_c),
        .data_o  (main_d)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ld_i    (skid_ld),
        .clr_i   (skid_clr),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (skid_v),
        .ctrl_o  (skid_c),
        .data_o  (skid_d)
    );

    assign out_valid_o = main_v;
    assign out_ctrl_o  = main_v ? main_c : '0;
    assign out_data_o  = main_d;
    assign count_o     = occupancy(main_v, skid_v);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: skid and non-skid stage registers checked against a queue model every cycle
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [7:0]   c;
        logic [127:0] d;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_v = 1'b0;
    logic         flush = 1'b0;
    logic         out_rdy = 1'b0;
    logic [7:0]   in_c = '0;
    logic [127:0] in_d = '0;
    logic         mon = 1'b0;

    logic         in_rdy [2];
    logic         out_v  [2];
    logic [7:0]   out_c  [2];
    logic [127:0] out_d  [2];
    logic [1:0]   cnt    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1)) p0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_v), .in_ready_o(in_rdy[0]),
        .in_ctrl_i(in_c), .in_data_i(in_d), .flush_i(flush), .out_valid_o(out_v[0]),
        .out_ready_i(out_rdy), .out_ctrl_o(out_c[0]), .out_data_o(out_d[0]), .count_o(cnt[0])
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0)) p1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_v), .in_ready_o(in_rdy[1]),
        .in_ctrl_i(in_c), .in_data_i(in_d), .flush_i(flush), .out_valid_o(out_v[1]),
        .out_ready_i(out_rdy), .out_ctrl_o(out_c[1]), .out_data_o(out_d[1]), .count_o(cnt[1])
    );

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        ent_t         q[$];
        logic         ok = 1'b0;
        logic [127:0] md = '0;
        int           sz = 0;
        logic [7:0]   fc = '0;

        // FIFO of capacity 2 (skid) or 1 (no skid); front of queue is what the output shows.
        always @(posedge clk or posedge rst) begin
            bit ir, ix, ox;
            if (rst) begin
                q.delete();
                ok = 1'b0;
                md = '0;
            end else begin
                ir = ok && ((g == 0) ? (q.size() < 2) : (q.size() == 0 || out_rdy));
                ix = in_v && ir;
                ox = (q.size() > 0) && out_rdy;
                if (flush)
                    q.delete();
                else begin
                    if (ox) void'(q.pop_front());
                    if (ix) q.push_back(ent_t'{in_c, in_d});
                end
                if (q.size() > 0) md = q[0].d;
                ok = 1'b1;
            end
            sz = q.size();
            fc = (sz > 0) ? q[0].c : 8'h00;
        end

        always @(negedge clk) begin
            logic rdy_e;
            if (mon) begin
                rdy_e = ok && ((g == 0) ? (sz < 2) : (sz == 0 || out_rdy));
                chk($sformatf("rdy%0d", g), in_rdy[g], rdy_e);
                chk($sformatf("valid%0d", g), out_v[g], sz > 0);
                chk($sformatf("ctrl%0d", g), out_c[g], fc);
                chk($sformatf("data%0d", g), out_d[g], md);
                chk($sformatf("count%0d", g), cnt[g], sz);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        mon = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rdy_after_release", in_rdy[0], 1'b0);
        chk("cnt_reset", cnt[0], 2'd0);
        chk("ctrl_reset", out_c[0], 8'h00);
        out_rdy = 1'b1;
        step();
        chk("rdy_first_edge", in_rdy[0], 1'b1);

        in_v = 1'b1;
        in_c = 8'h05;
        for (int i = 1; i <= 4; i++) begin
            in_d = 128'(i);
            step();
            chk("stream_data", out_d[0], 128'(i));
            chk("stream_cnt", cnt[0], 2'd1);
            chk("stream_rdy", in_rdy[0], 1'b1);
        end
        in_v = 1'b0;
        step();
        chk("stream_drain_ctrl", out_c[0], 8'h00);
        chk("model_hold", m[0].md, 128'h4);

        out_rdy = 1'b0;
        in_v = 1'b1;
        in_d = 128'hAA;
        step();
        chk("stall_cnt1", cnt[0], 2'd1);
        in_d = 128'hBB;
        step();
        chk("stall_cnt2", cnt[0], 2'd2);
        chk("stall_rdy0", in_rdy[0], 1'b0);
        chk("model_full", 128'(m[0].sz), 128'd2);
        in_d = 128'hCC;
        step();
        chk("stall_hold_aa", out_d[0], 128'hAA);
        out_rdy = 1'b1;
        step();
        chk("release_bb", out_d[0], 128'hBB);
        chk("release_cnt", cnt[0], 2'd1);
        step();
        chk("release_cc", out_d[0], 128'hCC);
        in_v = 1'b0;
        step();
        chk("release_empty", cnt[0], 2'd0);

        out_rdy = 1'b0;
        in_v = 1'b1;
        in_d = 128'h11;
        step();
        in_d = 128'h22;
        step();
        chk("pre_flush_cnt", cnt[0], 2'd2);
        flush = 1'b1;
        in_d = 128'hCC;
        step();
        chk("flush_valid", out_v[0], 1'b0);
        chk("flush_ctrl", out_c[0], 8'h00);
        chk("flush_cnt", cnt[0], 2'd0);
        flush = 1'b0;
        in_v = 1'b0;
        out_rdy = 1'b1;
        step();
        chk("flush_no_cc", out_d[0], 128'h11);

        in_v = 1'b1;
        in_c = 8'hFF;
        in_d = 128'h77;
        step();
        chk("bubble_ctrl_ff", out_c[0], 8'hFF);
        in_v = 1'b0;
        step();
        chk("bubble_ctrl_00", out_c[0], 8'h00);
        chk("bubble_data_hold", out_d[0], 128'h77);

        in_v = 1'b1;
        in_c = 8'h05;
        in_d = 128'h1;
        step();
        chk("noskid_valid", out_v[1], 1'b1);
        out_rdy = 1'b0;
        #1 chk("noskid_rdy_comb0", in_rdy[1], 1'b0);
        step();
        chk("noskid_cnt", cnt[1], 2'd1);
        out_rdy = 1'b1;
        #1 chk("noskid_rdy_comb1", in_rdy[1], 1'b1);
        step();
        in_v = 1'b0;
        step();
        step();
        step();

        out_rdy = 1'b0;
        in_v = 1'b1;
        in_d = 128'h31;
        step();
        in_d = 128'h32;
        step();
        chk("rstfull_cnt2", cnt[0], 2'd2);
        in_v = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstfull_valid", out_v[0], 1'b0);
        chk("rstfull_cnt", cnt[0], 2'd0);
        chk("rstfull_rdy", in_rdy[0], 1'b0);
        step();
        rst = 1'b0;
        step();
        in_v = 1'b1;
        out_rdy = 1'b1;
        in_d = 128'h55;
        step();
        chk("rstfull_latency", out_d[0], 128'h55);
        chk("rstfull_valid1", out_v[0], 1'b1);

        for (int i = 0; i < 3000; i++) begin
            in_v = $urandom_range(0, 3) != 0;
            out_rdy = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 15) == 0;
            in_c = 8'($urandom);
            in_d = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        flush = 1'b0;
        in_v = 1'b0;
        step();
        mon = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
